branch_resolve_unit: RTL and testbench

Tracks every conditional branch the global history predictor has predicted, from decode until its outcome resolves in the memory stage. Compares the prediction with the actual outcome, raises a one-cycle pipeline flush with the recovery PC on a mispredict, and keeps saturating branch/mispredict counters. Sits directly downstream of the global history predictor: it consumes `prediction` and `out_branch_addr` at decode and `actual_branch_decision` at memory.

---
 rtl/branch_resolve_unit_pkg.sv | 23 ++
 rtl/branch_inflight_fifo.sv | 68 ++++++
 rtl/branch_resolve_unit.sv | 105 ++++++++++
 tb/tb_branch_resolve_unit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared branch-tracking types: entry layout and PC arithmetic used by the
// predictor, fetch stage and the branch resolve unit.
package branch_resolve_unit_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;
  localparam int PC_W        = XLEN;
  localparam int TARGET_W    = XLEN;

  typedef struct packed {
    logic [PC_W-1:0]     pc;
    logic                taken;
    logic [TARGET_W-1:0] target;
  } br_entry_t;

  localparam int ENTRY_W = $bits(br_entry_t);

  // Fall-through PC; the carry out of the top bit is intentionally dropped.
  function automatic logic [XLEN-1:0] next_seq_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/branch_inflight_fifo.sv
// In-order store of predicted branches awaiting resolution. Pointers carry one
// extra wrap bit so full and empty are distinguishable without a counter.
module branch_inflight_fifo
  import branch_resolve_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  logic      clear,
  input  br_entry_t wr_entry,
  output br_entry_t rd_entry,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        wr_en;
  br_entry_t   mem_q [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    wr_en    = 1'b0;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // A push alongside a pop while full lands in the slot being read out this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
    end
  end

  assign rd_entry = mem_q[rd_ptr_q[AW-1:0]];
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/branch_resolve_unit.sv
// Tracks predicted branches from decode to memory, flags mispredicts with a
// registered one-cycle flush plus recovery PC, and keeps saturating counters.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pred_valid,
  input  logic             pred_taken,
  input  logic [XLEN-1:0]  pred_target,
  input  logic [XLEN-1:0]  pred_pc,
  input  logic             resolve_valid,
  input  logic             actual_taken,
  input  logic [XLEN-1:0]  actual_target,
  output logic             flush,
  output logic [XLEN-1:0]  recover_pc,
  output logic             queue_full,
  output logic             queue_empty,
  output logic             err_overflow,
  output logic             err_underflow,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  br_entry_t head;
  br_entry_t new_entry;
  logic      fifo_full, fifo_empty;
  logic      pop_ok, push_ok, mispredict;

  logic             flush_q, flush_d;
  logic [XLEN-1:0]  recover_pc_q, recover_pc_d;
  logic             err_overflow_q, err_overflow_d;
  logic             err_underflow_q, err_underflow_d;
  logic [CNT_W-1:0] branch_count_q, branch_count_d;
  logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;

  assign new_entry = '{pc: pred_pc, taken: pred_taken, target: pred_target};

  always_comb begin
    pop_ok     = resolve_valid && !fifo_empty;
    mispredict = pop_ok &&
                 ((head.taken != actual_taken) ||
                  (head.taken && actual_taken && (head.target != actual_target)));
    // Wrong-path pushes die with the flush; a correct pop frees a slot even when full.
    push_ok    = pred_valid && !mispredict && (!fifo_full || pop_ok);

    flush_d            = mispredict;
    recover_pc_d       = recover_pc_q;
    err_overflow_d     = err_overflow_q  || (pred_valid && fifo_full && !pop_ok);
    err_underflow_d    = err_underflow_q || (resolve_valid && fifo_empty);
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;

    if (mispredict) begin
      recover_pc_d = actual_taken ? actual_target : next_seq_pc(head.pc);
      if (mispredict_count_q != CNT_MAX) mispredict_count_d = mispredict_count_q + CNT_W'(1);
    end
    if (pop_ok && branch_count_q != CNT_MAX) branch_count_d = branch_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_q            <= 1'b0;
      recover_pc_q       <= '0;
      err_overflow_q     <= 1'b0;
      err_underflow_q    <= 1'b0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      flush_q            <= flush_d;
      recover_pc_q       <= recover_pc_d;
      err_overflow_q     <= err_overflow_d;
      err_underflow_q    <= err_underflow_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  branch_inflight_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_ok),
    .pop      (pop_ok),
    .clear    (mispredict),
    .wr_entry (new_entry),
    .rd_entry (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign flush            = flush_q;
  assign recover_pc       = recover_pc_q;
  assign queue_full       = fifo_full;
  assign queue_empty      = fifo_empty;
  assign err_overflow     = err_overflow_q;
  assign err_underflow    = err_underflow_q;
  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with DEPTH=4 and 4-bit counters.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        pred_valid, pred_taken, resolve_valid, actual_taken;
  logic [31:0] pred_target, pred_pc, actual_target;
  logic        flush, queue_full, queue_empty, err_overflow, err_underflow;
  logic [31:0] recover_pc;
  logic [3:0]  branch_count, mispredict_count;

  int errors = 0;
  int checks = 0;

  branch_resolve_unit #(.DEPTH(4), .CNT_W(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .pred_valid       (pred_valid),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .pred_pc          (pred_pc),
    .resolve_valid    (resolve_valid),
    .actual_taken     (actual_taken),
    .actual_target    (actual_target),
    .flush            (flush),
    .recover_pc       (recover_pc),
    .queue_full       (queue_full),
    .queue_empty      (queue_empty),
    .err_overflow     (err_overflow),
    .err_underflow    (err_underflow),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pred_valid    = 1'b0;
    pred_taken    = 1'b0;
    pred_target   = '0;
    pred_pc       = '0;
    resolve_valid = 1'b0;
    actual_taken  = 1'b0;
    actual_target = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic set_push(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    pred_valid  = 1'b1;
    pred_pc     = pc;
    pred_taken  = tk;
    pred_target = tgt;
  endtask

  task automatic set_resolve(input logic tk, input logic [31:0] tgt);
    resolve_valid = 1'b1;
    actual_taken  = tk;
    actual_target = tgt;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got=%0h exp=0", flush); end
    checks++; if (recover_pc !== 32'h0) begin errors++; $display("FAIL reset_recover_pc got=%08h exp=00000000", recover_pc); end
    checks++; if (queue_empty !== 1'b1 || queue_full !== 1'b0) begin errors++; $display("FAIL reset_queue empty=%0b full=%0b exp empty=1 full=0", queue_empty, queue_full); end
    checks++; if (err_overflow !== 1'b0 || err_underflow !== 1'b0) begin errors++; $display("FAIL reset_errors ovf=%0b unf=%0b exp 0 0", err_overflow, err_underflow); end
    checks++; if (branch_count !== 4'd0 || mispredict_count !== 4'd0) begin errors++; $display("FAIL reset_counts br=%0d mp=%0d exp 0 0", branch_count, mispredict_count); end
  endtask

  task automatic test_correct_prediction();
    do_reset();
    set_push(32'h100, 1'b1, 32'h140); step(); idle();
    checks++; if (queue_empty !== 1'b0) begin errors++; $display("FAIL correct_after_push_empty got=%0b exp=0", queue_empty); end
    set_resolve(1'b1, 32'h140); step(); idle();
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL correct_flush got=%0b exp=0", flush); end
    checks++; if (branch_count !== 4'd1 || mispredict_count !== 4'd0) begin errors++; $display("FAIL correct_counts br=%0d mp=%0d exp 1 0", branch_count, mispredict_count); end
    checks++; if (queue_empty !== 1'b1) begin errors++; $display("FAIL correct_empty got=%0b exp=1", queue_empty); end
    step();
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL correct_flush_later got=%0b exp=0", flush); end
  endtask

  task automatic test_direction_mispredict();
    do_reset();
    set_push(32'h200, 1'b0, 32'h0); step(); idle();
    set_resolve(1'b1, 32'h280); step(); idle();
    checks++; if (flush !== 1'b1 || recover_pc !== 32'h280) begin errors++; $display("FAIL dir_flush flush=%0b pc=%08h exp 1 00000280", flush, recover_pc); end
    checks++; if (mispredict_count !== 4'd1 || branch_count !== 4'd1) begin errors++; $display("FAIL dir_counts mp=%0d br=%0d exp 1 1", mispredict_count, branch_count); end
    step();
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL dir_flush_drop got=%0b exp=0", flush); end
    checks++; if (recover_pc !== 32'h280) begin errors++; $display("FAIL dir_recover_hold got=%08h exp=00000280", recover_pc); end
  endtask

  task automatic test_recovery_targets();
    do_reset();
    set_push(32'hFFFF_FFFC, 1'b1, 32'h10); step(); idle();
    set_resolve(1'b0, 32'h10); step(); idle();
    checks++; if (flush !== 1'b1 || recover_pc !== 32'h0) begin errors++; $display("FAIL wrap_recover flush=%0b pc=%08h exp 1 00000000", flush, recover_pc); end
    step();
    set_push(32'h300, 1'b1, 32'h340); step(); idle();
    set_resolve(1'b1, 32'h344); step(); idle();
    checks++; if (flush !== 1'b1 || recover_pc !== 32'h344) begin errors++; $display("FAIL target_mispredict flush=%0b pc=%08h exp 1 00000344", flush, recover_pc); end
    checks++; if (mispredict_count !== 4'd2) begin errors++; $display("FAIL target_mp_count got=%0d exp=2", mispredict_count); end
    step();
    set_push(32'h400, 1'b0, 32'h999); step(); idle();
    set_resolve(1'b0, 32'h123); step(); idle();
    checks++; if (flush !== 1'b0 || mispredict_count !== 4'd2 || branch_count !== 4'd3) begin errors++; $display("FAIL nt_correct flush=%0b mp=%0d br=%0d exp 0 2 3", flush, mispredict_count, branch_count); end
  endtask

  task automatic test_flush_squash();
    do_reset();
    set_push(32'h500, 1'b0, 32'h0); step();
    set_push(32'h504, 1'b0, 32'h0); step();
    set_push(32'h508, 1'b0, 32'h0); step();
    set_push(32'h50C, 1'b0, 32'h0);
    set_resolve(1'b1, 32'h700); step(); idle();
    checks++; if (flush !== 1'b1 || recover_pc !== 32'h700) begin errors++; $display("FAIL squash_flush flush=%0b pc=%08h exp 1 00000700", flush, recover_pc); end
    checks++; if (queue_empty !== 1'b1) begin errors++; $display("FAIL squash_empty got=%0b exp=1", queue_empty); end
    set_resolve(1'b1, 32'h0);
    set_push(32'h600, 1'b0, 32'h0); step(); idle();
    checks++; if (err_underflow !== 1'b1 || flush !== 1'b0) begin errors++; $display("FAIL squash_underflow unf=%0b flush=%0b exp 1 0", err_underflow, flush); end
    checks++; if (branch_count !== 4'd1 || queue_empty !== 1'b0) begin errors++; $display("FAIL underflow_push br=%0d empty=%0b exp 1 0", branch_count, queue_empty); end
    set_resolve(1'b0, 32'h0); step(); idle();
    checks++; if (flush !== 1'b0 || branch_count !== 4'd2 || queue_empty !== 1'b1) begin errors++; $display("FAIL underflow_push_entry flush=%0b br=%0d empty=%0b exp 0 2 1", flush, branch_count, queue_empty); end
    checks++; if (err_underflow !== 1'b1 || err_overflow !== 1'b0) begin errors++; $display("FAIL sticky_underflow unf=%0b ovf=%0b exp 1 0", err_underflow, err_overflow); end
  endtask

  task automatic test_full_boundary();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_push(32'h1000 + 32'(i * 16), 1'b1, 32'h1040 + 32'(i * 16)); step();
    end
    idle();
    checks++; if (queue_full !== 1'b1 || queue_empty !== 1'b0) begin errors++; $display("FAIL full_after4 full=%0b empty=%0b exp 1 0", queue_full, queue_empty); end
    set_push(32'hDEAD_0000, 1'b0, 32'h0); step(); idle();
    checks++; if (err_overflow !== 1'b1 || queue_full !== 1'b1) begin errors++; $display("FAIL overflow ovf=%0b full=%0b exp 1 1", err_overflow, queue_full); end
    set_push(32'h2000, 1'b1, 32'h2080);
    set_resolve(1'b1, 32'h1040); step(); idle();
    checks++; if (queue_full !== 1'b1 || flush !== 1'b0 || branch_count !== 4'd1) begin errors++; $display("FAIL full_push_pop full=%0b flush=%0b br=%0d exp 1 0 1", queue_full, flush, branch_count); end
    for (int i = 1; i < 4; i++) begin
      set_resolve(1'b1, 32'h1040 + 32'(i * 16)); step(); idle();
      checks++; if (flush !== 1'b0) begin errors++; $display("FAIL drain_%0d flush got=%0b exp=0", i, flush); end
    end
    set_resolve(1'b1, 32'h2080); step(); idle();
    checks++; if (flush !== 1'b0 || queue_empty !== 1'b1 || branch_count !== 4'd5) begin errors++; $display("FAIL drain_last flush=%0b empty=%0b br=%0d exp 0 1 5", flush, queue_empty, branch_count); end
    checks++; if (mispredict_count !== 4'd0 || err_underflow !== 1'b0) begin errors++; $display("FAIL drain_clean mp=%0d unf=%0b exp 0 0", mispredict_count, err_underflow); end
  endtask

  task automatic test_saturation_and_reset();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      set_push(32'h3000 + 32'(i * 4), 1'b0, 32'h0); step(); idle();
      set_resolve(1'b1, 32'h80); step(); idle();
    end
    checks++; if (mispredict_count !== 4'd15 || branch_count !== 4'd15) begin errors++; $display("FAIL saturate mp=%0d br=%0d exp 15 15", mispredict_count, branch_count); end
    step();
    set_push(32'h4000, 1'b0, 32'h0); step(); idle();
    set_resolve(1'b1, 32'h4444); step(); idle();
    checks++; if (flush !== 1'b1 || recover_pc !== 32'h4444) begin errors++; $display("FAIL pre_reset_flush flush=%0b pc=%08h exp 1 00004444", flush, recover_pc); end
    rst = 1'b1;
    #1;
    checks++; if (flush !== 1'b0 || recover_pc !== 32'h0) begin errors++; $display("FAIL async_reset_flush flush=%0b pc=%08h exp 0 00000000", flush, recover_pc); end
    checks++; if (mispredict_count !== 4'd0 || branch_count !== 4'd0 || queue_empty !== 1'b1) begin errors++; $display("FAIL async_reset_state mp=%0d br=%0d empty=%0b exp 0 0 1", mispredict_count, branch_count, queue_empty); end
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_correct_prediction();
    test_direction_mispredict();
    test_recovery_targets();
    test_flush_squash();
    test_full_boundary();
    test_saturation_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
